// File: rtl/fifo_byte_unpacker.sv
// fifo_byte_unpacker: reads 16-bit words from a FIFO and emits them as two bytes over a valid/ready stream
//   rclk       : single rising-edge clock
//   rst        : synchronous active-low reset
//   en         : permits starting a new FIFO read; a word already fetched always completes
//   fifo_empty : FIFO empty flag; fifo_data : registered FIFO read data (valid the cycle after rd_en)
//   rd_en      : one-cycle FIFO read strobe per fetched word
//   m_valid / m_ready / m_data : byte stream, transfer on m_valid && m_ready at posedge
//   busy       : high whenever the FSM is not idle
//   byte_cnt / word_cnt : free-running wrap-around counts of transferred bytes and fetched words
module fifo_byte_unpacker #(
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             rclk,
  input  logic             rst,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [15:0]      fifo_data,
  output logic             rd_en,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_data,
  output logic             busy,
  output logic [CNT_W-1:0] byte_cnt,
  output logic [CNT_W-1:0] word_cnt
);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND_A, SEND_B} state_t;
  state_t      state;
  logic [15:0] word;
  logic        fetch_ok;
  function automatic logic [7:0] first_byte(input logic [15:0] w);
    return MSB_FIRST ? w[15:8] : w[7:0];
  endfunction
  function automatic logic [7:0] second_byte(input logic [15:0] w);
    return MSB_FIRST ? w[7:0] : w[15:8];
  endfunction
  assign fetch_ok = en && !fifo_empty;
  assign rd_en    = state == FETCH;
  assign m_valid  = state == SEND_A || state == SEND_B;
  assign busy     = state != IDLE;
  always_ff @(posedge rclk) begin
    if (!rst) begin
      state    <= IDLE;
      word     <= '0;
      m_data   <= '0;
      byte_cnt <= '0;
      word_cnt <= '0;
    end else begin
      if (m_valid && m_ready) byte_cnt <= byte_cnt + CNT_W'(1);
      case (state)
        IDLE:    if (fetch_ok) state <= FETCH;
        FETCH: begin
          word_cnt <= word_cnt + CNT_W'(1);
          state    <= LOAD;
        end
        // the first byte is taken straight from the FIFO so it is on m_data as SEND_A begins
        LOAD: begin
          word   <= fifo_data;
          m_data <= first_byte(fifo_data);
          state  <= SEND_A;
        end
        SEND_A: if (m_ready) begin
          m_data <= second_byte(word);
          state  <= SEND_B;
        end
        SEND_B:  if (m_ready) state <= fetch_ok ? FETCH : IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_byte_unpacker.sv
// tb_fifo_byte_unpacker: directed bench with a byte-stream reference model for both byte orders
module tb_fifo_byte_unpacker;
  logic        rclk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        m_ready = 1'b0;
  logic        fifo_empty;
  logic [15:0] fifo_data = 16'h0;
  logic        rd_en, m_valid, busy;
  logic [7:0]  m_data;
  logic [15:0] byte_cnt, word_cnt;
  logic        l_rd_en, l_m_valid, l_busy;
  logic [7:0]  l_m_data;
  logic [3:0]  l_byte_cnt, l_word_cnt;

  fifo_byte_unpacker u_dut (
    .rclk(rclk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .rd_en(rd_en), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy),
    .byte_cnt(byte_cnt), .word_cnt(word_cnt)
  );

  fifo_byte_unpacker #(.MSB_FIRST(1'b0), .CNT_W(4)) u_lsb (
    .rclk(rclk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .rd_en(l_rd_en), .m_valid(l_m_valid), .m_ready(m_ready), .m_data(l_m_data), .busy(l_busy),
    .byte_cnt(l_byte_cnt), .word_cnt(l_word_cnt)
  );

  always #5 rclk = ~rclk;

  logic [15:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = wr_ptr == rd_ptr;
  always @(posedge rclk)
    if (rd_en && !fifo_empty) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end

  int n_chk = 0;
  int n_pass = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  logic [7:0] exp_m [$];
  logic [7:0] exp_l [$];
  logic [7:0] hs_log [$];
  int mb_cnt = 0;
  int mw_cnt = 0;
  int tot_rd = 0;
  bit armed = 0;
  bit prev_stall = 0;

  always @(negedge rclk) begin
    if (armed) begin
      chk("byte_cnt", 32'(byte_cnt), 32'(mb_cnt % 65536));
      chk("word_cnt", 32'(word_cnt), 32'(mw_cnt % 65536));
      chk("lsb_byte_cnt", 32'(l_byte_cnt), 32'(mb_cnt % 16));
      chk("lsb_word_cnt", 32'(l_word_cnt), 32'(mw_cnt % 16));
      chk("lsb_valid_match", 32'(l_m_valid), 32'(m_valid));
      chk("lsb_rd_match", 32'(l_rd_en), 32'(rd_en));
      if (rd_en && fifo_empty) chk("rd_while_empty", 32'(rd_en), 32'(0));
      if (m_valid || rd_en) chk("busy_active", 32'(busy), 32'(1));
      if (prev_stall) chk("hold_valid", 32'(m_valid), 32'(1));
      if (m_valid) begin
        if (exp_m.size() == 0) chk("spurious_valid", 32'(m_valid), 32'(0));
        else begin
          chk("m_data", 32'(m_data), 32'(exp_m[0]));
          chk("lsb_m_data", 32'(l_m_data), 32'(exp_l[0]));
        end
      end
    end
    if (rd_en) tot_rd++;
    if (!rst) begin
      exp_m.delete();
      exp_l.delete();
      mb_cnt = 0;
      mw_cnt = 0;
      prev_stall = 0;
      armed = 1;
    end else if (armed) begin
      if (m_valid && m_ready) begin
        hs_log.push_back(m_data);
        mb_cnt++;
        if (exp_m.size() != 0) begin
          void'(exp_m.pop_front());
          void'(exp_l.pop_front());
        end
      end
      if (rd_en && !fifo_empty) begin
        mw_cnt++;
        exp_m.push_back(mem[rd_ptr][15:8]);
        exp_m.push_back(mem[rd_ptr][7:0]);
        exp_l.push_back(mem[rd_ptr][7:0]);
        exp_l.push_back(mem[rd_ptr][15:8]);
      end
      prev_stall = m_valid && !m_ready;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge rclk);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  task automatic chk_log(input string nm, input int base, input int n, input logic [63:0] bytes);
    chk({nm, "_len"}, 32'(hs_log.size() - base), 32'(n));
    if (hs_log.size() - base == n)
      for (int k = 0; k < n; k++) chk(nm, 32'(hs_log[base + k]), 32'(bytes[8 * (n - 1 - k) +: 8]));
  endtask

  int hb, rb;
  initial begin
    tick(2);
    chk("rst_rd_en", 32'(rd_en), 32'(0));
    chk("rst_m_valid", 32'(m_valid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_m_data", 32'(m_data), 32'(0));
    chk("rst_byte_cnt", 32'(byte_cnt), 32'(0));
    chk("rst_word_cnt", 32'(word_cnt), 32'(0));
    rst = 1'b1;
    en = 1'b1;
    m_ready = 1'b1;
    push(16'hA55A);
    tick(1);
    chk("t1_fetch_rd", 32'(rd_en), 32'(1));
    chk("t1_fetch_valid", 32'(m_valid), 32'(0));
    tick(1);
    chk("t1_load_rd", 32'(rd_en), 32'(0));
    chk("t1_load_valid", 32'(m_valid), 32'(0));
    tick(1);
    chk("t1_a_valid", 32'(m_valid), 32'(1));
    chk("t1_a_data", 32'(m_data), 32'hA5);
    chk("t1_a_lsb_data", 32'(l_m_data), 32'h5A);
    tick(1);
    chk("t1_b_data", 32'(m_data), 32'h5A);
    chk("t1_b_lsb_data", 32'(l_m_data), 32'hA5);
    tick(1);
    chk("t1_idle_busy", 32'(busy), 32'(0));
    chk("t1_byte_cnt", 32'(byte_cnt), 32'(2));
    chk("t1_word_cnt", 32'(word_cnt), 32'(1));
    m_ready = 1'b0;
    push(16'hA55A);
    tick(3);
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", 32'(m_valid), 32'(1));
      chk("t2_hold_data", 32'(m_data), 32'hA5);
      chk("t2_hold_rd", 32'(rd_en), 32'(0));
      tick(1);
    end
    m_ready = 1'b1;
    chk("t2_release_data", 32'(m_data), 32'hA5);
    tick(1);
    chk("t2_second_data", 32'(m_data), 32'h5A);
    tick(1);
    chk("t2_byte_cnt", 32'(byte_cnt), 32'(4));
    chk("t2_word_cnt", 32'(word_cnt), 32'(2));
    hb = hs_log.size();
    rb = tot_rd;
    push(16'h0102);
    push(16'h0304);
    push(16'h0506);
    for (int i = 0; i < 12; i++) begin
      tick(1);
      chk("t3_no_idle", 32'(busy), 32'(1));
    end
    tick(1);
    chk("t3_idle", 32'(busy), 32'(0));
    chk("t3_rd_pulses", 32'(tot_rd - rb), 32'(3));
    chk_log("t3_bytes", hb, 6, 64'h0000_0102_0304_0506);
    rb = tot_rd;
    tick(10);
    chk("t4_empty_rd", 32'(tot_rd - rb), 32'(0));
    chk("t4_empty_busy", 32'(busy), 32'(0));
    hb = hs_log.size();
    m_ready = 1'b0;
    push(16'h1122);
    push(16'h3344);
    tick(3);
    chk("t5_a_data", 32'(m_data), 32'h11);
    en = 1'b0;
    m_ready = 1'b1;
    tick(2);
    chk("t5_idle", 32'(busy), 32'(0));
    tick(5);
    chk("t5_held_rd", 32'(tot_rd - rb), 32'(1));
    chk("t5_held_busy", 32'(busy), 32'(0));
    en = 1'b1;
    tick(1);
    chk("t5_resume_rd", 32'(rd_en), 32'(1));
    tick(4);
    chk("t5_rd_pulses", 32'(tot_rd - rb), 32'(2));
    chk_log("t5_bytes", hb, 4, 64'h0000_0000_1122_3344);
    push(16'hDEAD);
    push(16'hBEEF);
    tick(4);
    chk("t6_b_data", 32'(m_data), 32'hAD);
    rst = 1'b0;
    tick(1);
    chk("t6_rst_valid", 32'(m_valid), 32'(0));
    chk("t6_rst_rd", 32'(rd_en), 32'(0));
    chk("t6_rst_busy", 32'(busy), 32'(0));
    chk("t6_rst_data", 32'(m_data), 32'(0));
    chk("t6_rst_byte_cnt", 32'(byte_cnt), 32'(0));
    chk("t6_rst_word_cnt", 32'(word_cnt), 32'(0));
    rst = 1'b1;
    hb = hs_log.size();
    tick(6);
    chk("t6_byte_cnt", 32'(byte_cnt), 32'(2));
    chk("t6_word_cnt", 32'(word_cnt), 32'(1));
    chk_log("t6_bytes", hb, 2, 64'h0000_0000_0000_BEEF);
    for (int i = 0; i < 7; i++) push(16'(16'h1020 + i * 16'h0101));
    tick(30);
    chk("t7_byte_cnt", 32'(byte_cnt), 32'(16));
    chk("t7_lsb_byte_wrap", 32'(l_byte_cnt), 32'(0));
    chk("t7_word_cnt", 32'(word_cnt), 32'(8));
    chk("t7_lsb_word_cnt", 32'(l_word_cnt), 32'(8));
    chk("t7_idle", 32'(busy), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
